// File: rtl/tribus_rx_fifo.sv
// Receive end of the shared 4-bit tri-state data bus.
// While the driver enable is high, the bus value is sampled into a small
// show-ahead FIFO for a local consumer. The block also keeps the last
// accepted word and sticky overflow/underflow flags.
module tribus_rx_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bus_en,
  input  logic [WIDTH-1:0] i_bus_d,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_q,
  output logic [WIDTH-1:0] o_last_q,
  output logic [AW:0]      o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  // Storage has no reset; its contents are meaningless until written.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last_q;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_underrun;

  // Occupancy decode and transfer qualification.
  // A pop needs a stored word, so a push into an empty FIFO is never
  // bypassed to the reader in the same cycle. A full FIFO still accepts a
  // word when the head leaves on the same edge.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == (AW + 1)'(DEPTH));
    w_pop      = i_rd_en & ~w_empty;
    w_push     = i_bus_en & (~w_full | w_pop);
    w_drop     = i_bus_en & ~w_push;
    w_underrun = i_rd_en & w_empty;
  end

  // Storage write port; suppressed on a reset edge.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_mem[r_wr_ptr] <= i_bus_d;
    end
  end

  // Pointers, occupancy, last-word register and sticky status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_q    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_last_q <= i_bus_d;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_underrun) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Show-ahead head word; forced to zero while nothing is stored so the
  // output is clean after reset.
  always_comb begin
    o_rd_q = w_empty ? '0 : r_mem[r_rd_ptr];
  end

  assign o_last_q    = r_last_q;
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule
